// File: rtl/debounced_button_array.sv
// Multi-channel button front end: per-channel synchroniser, polarity fix, debounce,
// and registered press / release / long-press event pulses.
module debounced_button_array #(
  parameter int CHANNELS         = 4,
  parameter int DEBOUNCE_CYCLES  = 100,
  parameter int LONGPRESS_CYCLES = 50000,
  parameter int SYNC_STAGES      = 2,
  parameter int ACTIVE_LOW       = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] in,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] pressed,
  output logic [CHANNELS-1:0] released,
  output logic [CHANNELS-1:0] long_press
);

  localparam int              DW        = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0]   DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic            IDLE_PIN  = (ACTIVE_LOW != 0);
  localparam int              HW        = (LONGPRESS_CYCLES > 0) ? $clog2(LONGPRESS_CYCLES + 1) : 1;
  localparam logic [HW-1:0]   HOLD_LAST = HW'((LONGPRESS_CYCLES > 0) ? LONGPRESS_CYCLES - 1 : 0);

  if (CHANNELS < 1) begin : g_bad_channels
    $error("debounced_button_array: CHANNELS must be >= 1");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("debounced_button_array: DEBOUNCE_CYCLES must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("debounced_button_array: SYNC_STAGES must be >= 2");
  end

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_reg;
      logic [DW-1:0]          db_cnt_reg;
      logic                   level_reg;
      logic                   pressed_reg;
      logic                   released_reg;
      logic                   sample;
      logic                   flip;

      always_ff @(posedge clk) begin
        if (rst) begin
          sync_reg <= {SYNC_STAGES{IDLE_PIN}};
        end else begin
          sync_reg <= {sync_reg[SYNC_STAGES-2:0], in[gi]};
        end
      end

      assign sample = sync_reg[SYNC_STAGES-1] ^ IDLE_PIN;
      // The level toggles on the edge where the disagreement has lasted DEBOUNCE_CYCLES samples.
      assign flip   = (sample != level_reg) && (db_cnt_reg == DB_LAST);

      always_ff @(posedge clk) begin
        if (rst) begin
          db_cnt_reg   <= '0;
          level_reg    <= 1'b0;
          pressed_reg  <= 1'b0;
          released_reg <= 1'b0;
        end else begin
          pressed_reg  <= flip && !level_reg;
          released_reg <= flip && level_reg;
          if ((sample == level_reg) || flip) begin
            db_cnt_reg <= '0;
          end else begin
            db_cnt_reg <= db_cnt_reg + DW'(1);
          end
          if (flip) begin
            level_reg <= !level_reg;
          end
        end
      end

      assign level[gi]    = level_reg;
      assign pressed[gi]  = pressed_reg;
      assign released[gi] = released_reg;

      if (LONGPRESS_CYCLES > 0) begin : g_long
        logic [HW-1:0] hold_reg;
        logic          fired_reg;
        logic          long_reg;

        // Counting stops once fired, so the hold counter never exceeds LONGPRESS_CYCLES.
        always_ff @(posedge clk) begin
          if (rst) begin
            hold_reg  <= '0;
            fired_reg <= 1'b0;
            long_reg  <= 1'b0;
          end else begin
            long_reg <= 1'b0;
            if (!level_reg) begin
              hold_reg  <= '0;
              fired_reg <= 1'b0;
            end else if (!fired_reg) begin
              if ((hold_reg == HOLD_LAST) && !flip) begin
                long_reg  <= 1'b1;
                fired_reg <= 1'b1;
              end
              hold_reg <= hold_reg + HW'(1);
            end
          end
        end

        assign long_press[gi] = long_reg;
      end else begin : g_no_long
        assign long_press[gi] = 1'b0;
      end
    end
  endgenerate

endmodule

// File: tb/tb_debounced_button_array.sv
// Bench for debounced_button_array: directed scenarios plus random pin activity,
// every cycle compared against a run-length / timestamp reference model.
module tb_debounced_button_array;
  localparam int CH = 3;
  localparam int DB = 4;
  localparam int LP = 10;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CH-1:0] in  = '1;
  logic [CH-1:0] level, pressed, released, long_press;

  always #5 clk = ~clk;

  debounced_button_array #(
    .CHANNELS(CH), .DEBOUNCE_CYCLES(DB), .LONGPRESS_CYCLES(LP),
    .SYNC_STAGES(SS), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .in(in), .level(level),
    .pressed(pressed), .released(released), .long_press(long_press)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_press[CH], n_rel[CH], n_long[CH];
  int t_press[CH], t_rel[CH], t_long[CH];

  // Reference model: pins reach the debouncer SS edges after sampling; the level flips once
  // the sample has disagreed for DB consecutive edges; long press is a timestamp match.
  logic [CH-1:0] m_level, e_pressed, e_released, e_long;
  logic [CH-1:0] pin_q[$];
  int            run[CH];
  int            rise_at[CH];
  int            edge_n;

  task automatic model_edge(input logic [CH-1:0] pin, input logic r);
    logic [CH-1:0] s;
    e_pressed  = '0;
    e_released = '0;
    e_long     = '0;
    if (r) begin
      m_level = '0;
      pin_q.delete();
      edge_n = 0;
      for (int c = 0; c < CH; c++) begin
        run[c]     = 0;
        rise_at[c] = -1000;
      end
    end else begin
      s = (pin_q.size() >= SS) ? ~pin_q[pin_q.size() - SS] : '0;
      for (int c = 0; c < CH; c++) begin
        if (s[c] != m_level[c]) run[c]++;
        else run[c] = 0;
        if (run[c] == DB) begin
          run[c]     = 0;
          m_level[c] = ~m_level[c];
          if (m_level[c]) begin
            e_pressed[c] = 1'b1;
            rise_at[c]   = edge_n;
          end else begin
            e_released[c] = 1'b1;
          end
        end
        if (m_level[c] && (edge_n == rise_at[c] + LP)) e_long[c] = 1'b1;
      end
      pin_q.push_back(pin);
      if (pin_q.size() > SS) void'(pin_q.pop_front());
      edge_n++;
    end
  endtask

  task automatic check(input string tag, input logic [CH-1:0] got, input logic [CH-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d: got %b expected %b", tag, cyc, got, exp);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_counts();
    for (int c = 0; c < CH; c++) begin
      n_press[c] = 0; n_rel[c] = 0; n_long[c] = 0;
      t_press[c] = -1; t_rel[c] = -1; t_long[c] = -1;
    end
  endtask

  task automatic tick(input logic [CH-1:0] pin, input logic r);
    @(negedge clk);
    in  = pin;
    rst = r;
    @(posedge clk);
    #1;
    cyc++;
    model_edge(pin, r);
    check("level", level, m_level);
    check("pressed", pressed, e_pressed);
    check("released", released, e_released);
    check("long_press", long_press, e_long);
    for (int c = 0; c < CH; c++) begin
      if (pressed[c] === 1'b1)    begin n_press[c]++; t_press[c] = cyc; end
      if (released[c] === 1'b1)   begin n_rel[c]++;   t_rel[c]   = cyc; end
      if (long_press[c] === 1'b1) begin n_long[c]++;  t_long[c]  = cyc; end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick('1, 1'b0);
  endtask

  initial begin
    int            c1;
    int            r1;
    logic [CH-1:0] pin_r;
    int            hold_left[CH];

    clear_counts();
    // 1: reset with pins idle, then idle after release
    for (int k = 0; k < 3; k++) tick(3'b111, 1'b1);
    idle(4);
    check("s1_level", level, 3'b000);

    // 2: clean press on channel 0, level after the 6th edge
    clear_counts();
    tick(3'b110, 1'b0);
    c1 = cyc;
    for (int k = 0; k < 5; k++) tick(3'b110, 1'b0);
    check("s2_level", level, 3'b001);
    check("s2_pressed", pressed, 3'b001);
    tick(3'b110, 1'b0);
    check("s2_pressed_once", pressed, 3'b000);
    check_int("s2_press_lat", t_press[0] - c1, 5);
    idle(20);

    // 3: short glitches on channel 1 never register
    clear_counts();
    for (int k = 0; k < 5; k++) begin
      for (int j = 0; j < 3; j++) tick(3'b101, 1'b0);
      for (int j = 0; j < 2; j++) tick(3'b111, 1'b0);
    end
    idle(8);
    check_int("s3_press_cnt", n_press[1], 0);
    check_int("s3_rel_cnt", n_rel[1], 0);

    // 4: long hold on channel 2
    clear_counts();
    tick(3'b011, 1'b0);
    c1 = cyc;
    for (int k = 0; k < 29; k++) tick(3'b011, 1'b0);
    tick(3'b111, 1'b0);
    r1 = cyc;
    idle(12);
    check_int("s4_press_lat", t_press[2] - c1, 5);
    check_int("s4_long_delay", t_long[2] - t_press[2], LP);
    check_int("s4_long_cnt", n_long[2], 1);
    check_int("s4_rel_lat", t_rel[2] - r1, 5);
    check("s4_level", level, 3'b000);

    // 5: release 9, 10 and 11 cycles after pressed[0]; only the last crosses the threshold
    for (int hold = 9; hold <= 11; hold++) begin
      clear_counts();
      for (int k = 0; k < hold; k++) tick(3'b110, 1'b0);
      idle(14);
      check_int("s5_rel_delay", t_rel[0] - t_press[0], hold);
      check_int("s5_long_cnt", n_long[0], (hold > LP) ? 1 : 0);
      check_int("s5_rel_cnt", n_rel[0], 1);
    end

    // 6: reset two cycles after a simultaneous press, then re-press with pins held low
    clear_counts();
    for (int k = 0; k < 7; k++) tick(3'b100, 1'b0);
    tick(3'b100, 1'b1);
    check("s6_level_rst", level, 3'b000);
    tick(3'b100, 1'b0);
    c1 = cyc;
    for (int k = 0; k < 8; k++) tick(3'b100, 1'b0);
    check_int("s6_rel_cnt0", n_rel[0], 0);
    check_int("s6_rel_cnt1", n_rel[1], 0);
    check_int("s6_repress0", t_press[0] - c1, 5);
    check_int("s6_repress1", t_press[1] - c1, 5);
    idle(20);

    // Random pin activity with mixed glitch and hold lengths, occasional reset
    pin_r = '1;
    for (int c = 0; c < CH; c++) hold_left[c] = $urandom_range(1, 24);
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < CH; c++) begin
        if (hold_left[c] == 0) begin
          pin_r[c]     = ~pin_r[c];
          hold_left[c] = $urandom_range(1, 24);
        end else begin
          hold_left[c]--;
        end
      end
      tick(pin_r, ($urandom_range(0, 399) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
